// File: rtl/sdram_device_model.sv
// rtl/sdram_device_model.sv - pin-level SDRAM responder with bank timing and protocol checking
module sdram_device_model #(
  parameter int ROW_BITS = 2,
  parameter int READ_LAT = 2,
  parameter int T_RCD    = 3,
  parameter int T_RP     = 3,
  parameter int T_RFC    = 7,
  parameter int REFI_MAX = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_cle,
  input  logic        sdram_cs,
  input  logic        sdram_ras,
  input  logic        sdram_cas,
  input  logic        sdram_we,
  input  logic        sdram_dqm,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_a,
  input  logic [31:0] dq_in,
  output logic [31:0] dq_out,
  output logic        dq_out_valid,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [12:0] mode_reg,
  output logic [15:0] refresh_count
);

  typedef enum logic [1:0] {
    BANK_IDLE,
    BANK_ACTIVATING,
    BANK_ACTIVE,
    BANK_PRECHARGING
  } bank_state_e;

  localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int RFW  = (T_RFC > 1) ? $clog2(T_RFC) : 1;
  localparam int WDW  = $clog2(REFI_MAX + 2);
  localparam int AW   = 2 + ROW_BITS + 8;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_TRM = 3'b110;

  bank_state_e         bank_q [4];
  logic [TW-1:0]       btmr_q [4];
  logic [ROW_BITS-1:0] row_q  [4];
  logic [RFW-1:0]      rfc_q;
  logic [WDW-1:0]      wd_q;
  logic [31:0]         mem_q [2**AW];
  logic [31:0]         dq_out_q;
  logic                dq_out_valid_q;
  logic                err_q;
  logic [2:0]          err_code_q;
  logic [12:0]         mode_reg_q;
  logic [15:0]         refresh_count_q;

  logic [3:0]    idle_now;
  logic [3:0]    open_now;
  logic          live;
  logic [2:0]    rcw;
  logic          do_act, do_rd, do_wr, do_pre, do_ref, do_lmr;
  logic [2:0]    cmd_err;
  logic [2:0]    err_d;
  logic          wd_expire;
  logic [AW-1:0] addr;
  logic [32:0]   rd_in;
  logic [32:0]   rd_tail;

  // A bank whose timer has run out is already usable in the same cycle.
  always_comb begin
    idle_now = '0;
    open_now = '0;
    for (int b = 0; b < 4; b++) begin
      idle_now[b] = (bank_q[b] == BANK_IDLE) ||
                    (bank_q[b] == BANK_PRECHARGING && btmr_q[b] == '0);
      open_now[b] = (bank_q[b] == BANK_ACTIVE) ||
                    (bank_q[b] == BANK_ACTIVATING && btmr_q[b] == '0);
    end
  end

  assign live = sdram_cle && !sdram_cs;
  assign rcw  = {sdram_ras, sdram_cas, sdram_we};
  assign addr = {sdram_ba, row_q[sdram_ba], sdram_a[7:0]};

  always_comb begin
    cmd_err = 3'd0;
    do_act  = 1'b0;
    do_rd   = 1'b0;
    do_wr   = 1'b0;
    do_pre  = 1'b0;
    do_ref  = 1'b0;
    do_lmr  = 1'b0;
    if (live && rcw != CMD_NOP) begin
      if (rfc_q != '0) begin
        cmd_err = 3'd4;
      end else begin
        case (rcw)
          CMD_ACT: if (idle_now[sdram_ba]) do_act = 1'b1; else cmd_err = 3'd1;
          CMD_RD:  if (open_now[sdram_ba]) do_rd  = 1'b1; else cmd_err = 3'd2;
          CMD_WR:  if (open_now[sdram_ba]) do_wr  = 1'b1; else cmd_err = 3'd2;
          CMD_PRE: do_pre = 1'b1;
          CMD_REF: if (&idle_now) do_ref = 1'b1; else cmd_err = 3'd3;
          CMD_LMR: if (&idle_now) do_lmr = 1'b1; else cmd_err = 3'd3;
          CMD_TRM: cmd_err = 3'd0;
          default: cmd_err = 3'd6;
        endcase
      end
    end
  end

  assign wd_expire = (wd_q >= WDW'(REFI_MAX)) && !do_ref;

  always_comb begin
    err_d = cmd_err;
    if (wd_expire && (cmd_err == 3'd0 || cmd_err > 3'd5)) err_d = 3'd5;
  end

  // Read data is captured in the command cycle so a following write cannot alter it.
  assign rd_in = {do_rd && !sdram_dqm, mem_q[addr]};

  generate
    if (READ_LAT == 1) begin : g_direct
      assign rd_tail = rd_in;
    end else begin : g_pipe
      logic [32:0] pipe_q [READ_LAT-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < READ_LAT - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= rd_in;
          for (int i = 1; i < READ_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign rd_tail = pipe_q[READ_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst && do_wr && !sdram_dqm) mem_q[addr] <= dq_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        bank_q[b] <= BANK_IDLE;
        btmr_q[b] <= '0;
        row_q[b]  <= '0;
      end
      rfc_q           <= '0;
      wd_q            <= '0;
      dq_out_q        <= '0;
      dq_out_valid_q  <= 1'b0;
      err_q           <= 1'b0;
      err_code_q      <= 3'd0;
      mode_reg_q      <= '0;
      refresh_count_q <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (do_pre && (sdram_a[10] || sdram_ba == 2'(b))) begin
          bank_q[b] <= BANK_PRECHARGING;
          btmr_q[b] <= TW'(T_RP - 1);
        end else if (do_act && sdram_ba == 2'(b)) begin
          bank_q[b] <= BANK_ACTIVATING;
          btmr_q[b] <= TW'(T_RCD - 1);
          row_q[b]  <= sdram_a[ROW_BITS-1:0];
        end else begin
          case (bank_q[b])
            BANK_ACTIVATING:
              if (btmr_q[b] == '0) bank_q[b] <= BANK_ACTIVE;
              else btmr_q[b] <= btmr_q[b] - 1'b1;
            BANK_PRECHARGING:
              if (btmr_q[b] == '0) bank_q[b] <= BANK_IDLE;
              else btmr_q[b] <= btmr_q[b] - 1'b1;
            default: btmr_q[b] <= '0;
          endcase
        end
      end

      if (do_ref) rfc_q <= RFW'(T_RFC - 1);
      else if (rfc_q != '0) rfc_q <= rfc_q - 1'b1;

      if (do_ref) wd_q <= '0;
      else if (wd_q < WDW'(REFI_MAX)) wd_q <= wd_q + 1'b1;

      if (do_ref) refresh_count_q <= refresh_count_q + 16'd1;
      if (do_lmr) mode_reg_q <= sdram_a;

      if (!err_q && err_d != 3'd0) begin
        err_q      <= 1'b1;
        err_code_q <= err_d;
      end

      dq_out_valid_q <= rd_tail[32];
      if (rd_tail[32]) dq_out_q <= rd_tail[31:0];
    end
  end

  assign dq_out        = dq_out_q;
  assign dq_out_valid  = dq_out_valid_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign mode_reg      = mode_reg_q;
  assign refresh_count = refresh_count_q;

endmodule

// File: doc/sdram_device_model.md
Name: sdram_device_model

Overview:
- Synthesizable single-rank, 32-bit-wide SDRAM responder: the memory-side partner of the team's SDRAM controller, sitting on the other end of the same pin bundle.
- Decodes CS/RAS/CAS/WE commands and tracks per-bank row state and timing.
- Stores write data and returns read data after a fixed latency.
- Flags protocol/timing violations so controller benches self-check at the pin level.

Parameters:
- ROW_BITS, 2, implemented row-address bits; the upper row bits of a[12:0] are ignored. Memory depth = 4 banks x 2^ROW_BITS rows x 256 columns.
- READ_LAT, 2, cycles from the READ command cycle to the cycle in which data is valid on dq_out (min 1).
- T_RCD, 3, minimum cycles from ACTIVE to READ/WRITE on the same bank.
- T_RP, 3, minimum cycles from PRECHARGE to ACTIVE/REFRESH.
- T_RFC, 7, minimum cycles from REFRESH to any non-NOP command.
- REFI_MAX, 1023, maximum cycles allowed between REFRESH commands before an error is flagged.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- sdram_cle  in  1  clock enable; commands are ignored when 0
- sdram_cs  in  1  chip select, active low
- sdram_ras  in  1  row strobe
- sdram_cas  in  1  column strobe
- sdram_we  in  1  write enable
- sdram_dqm  in  1  data mask
- sdram_ba  in  2  bank address
- sdram_a  in  13  row/column address
- dq_in  in  32  write data (driven by the controller)
- dq_out  out  32  read data (sampled by the controller)
- dq_out_valid  out  1  dq_out carries the data of a read
- err  out  1  sticky violation flag
- err_code  out  3  code of the first violation
- mode_reg  out  13  last LOAD_MODE_REG value
- refresh_count  out  16  number of REFRESH commands accepted, wrapping

Behaviour:
- Reset values: dq_out=0, dq_out_valid=0, err=0, err_code=0, mode_reg=0, refresh_count=0.
- Reset also: all banks IDLE, timers 0, read pipeline flushed, refresh watchdog 0.
- The memory array is not cleared by reset. Reset mid-read drops the pending data.
- Command decode: {cs,ras,cas,we} sampled each rising edge when cle=1; cle=0 or cs=1 is treated as NOP. Timers and watchdog keep counting in both cases.
  - 0111 NOP
  - 0011 ACTIVE
  - 0101 READ
  - 0100 WRITE
  - 0010 PRECHARGE
  - 0001 REFRESH
  - 0000 LOAD_MODE_REG
  - 0110 TERMINATE (accepted, no effect)
- Per-bank FSM: IDLE -> (ACTIVE) ACTIVATING -> after T_RCD cycles -> ACTIVE -> (PRECHARGE) PRECHARGING -> after T_RP cycles -> IDLE. Each bank stores its open row, a[ROW_BITS-1:0].
- PRECHARGE: a[10]=1 closes all banks; a[10]=0 closes bank ba. Precharging an IDLE bank is legal and restarts its T_RP timer.
- READ/WRITE: column = a[7:0]; the word address is {ba, open row, col}.
  - WRITE stores dq_in in the WRITE command cycle unless dqm=1, in which case the write is masked.
  - READ: the memory word appears on dq_out with dq_out_valid=1 in cycle c+READ_LAT, where c is the READ command cycle. dq_out_valid is high for one cycle; dq_out holds its value afterwards.
  - dqm=1 on a READ: the read runs, but dq_out_valid stays 0 for it.
  - Back-to-back reads are pipelined, one per cycle.
  - A WRITE to the same address as an in-flight READ does not alter that read's data.
- REFRESH: legal only with all banks IDLE. Increments refresh_count, clears the watchdog, and blocks non-NOP commands for T_RFC cycles.
- LOAD_MODE_REG: legal only with all banks IDLE; mode_reg <= a. This is informational only; READ_LAT stays fixed.
- Error codes (first error wins; err stays set until reset):
  - 1: ACTIVE to a bank not IDLE or still in T_RP
  - 2: READ/WRITE to a bank not ACTIVE, including during T_RCD
  - 3: REFRESH/LMR with any bank not IDLE
  - 4: any command during T_RFC
  - 5: watchdog exceeded REFI_MAX
  - 6: unused/illegal encoding
- Simultaneous events: a READ retiring on dq_out in the same cycle a new READ is issued is normal. A watchdog expiry coincident with another violation reports the lower code.

Test Plan:
- ACTIVE ba=1 row=2; WRITE col=0x10 data=0xDEADBEEF 3 cycles later; READ col=0x10 -> dq_out=0xDEADBEEF with valid exactly 2 cycles after READ, err=0.
- READ issued 2 cycles after ACTIVE -> err=1, err_code=2. Then reset -> err=0, all outputs zero, previously written data still readable.
- WRITE 0x11111111 with dqm=0, then WRITE 0x22222222 with dqm=1 at the same address; READ -> 0x11111111. A READ with dqm=1 -> dq_out_valid never asserts.
- Banks 0 and 1 active; PRECHARGE a[10]=1; REFRESH 3 cycles later -> refresh_count=1. NOP issued 3 cycles after REFRESH is fine; ACTIVE issued 3 cycles after REFRESH -> err_code=4.
- No REFRESH for 1024 cycles -> err_code=5.
- ACTIVE to an already active bank -> err_code=1. Drive the team's controller through mixed row-hit/row-miss traffic at 4 reads in a row -> all returned data matches the write history, err=0.
